// File: rtl/arb_pkg.sv
// Shared types and default sizes for the round-robin memory arbiter.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } arb_state_t;

    localparam int ARB_AN    = 24;
    localparam int ARB_DN    = 16;
    localparam int ARB_BURST = 8;

endpackage

// File: rtl/arb_rr_if.sv
// Downstream memory command/return bus between the arbiter (master) and the
// memory controller (slave).
interface arb_rr_if
    import arb_pkg::*;
#(
    parameter int AN = ARB_AN,
    parameter int DN = ARB_DN,
    parameter int IN = 2
);

    logic          mem_req;
    logic          mem_wr;
    logic [AN-1:0] mem_addr;
    logic [DN-1:0] mem_data;
    logic [IN-1:0] mem_id;
    logic          mem_ack;
    logic          mem_valid;
    logic [IN-1:0] mem_rid;

    modport master (
        output mem_req, mem_wr, mem_addr, mem_data, mem_id,
        input  mem_ack, mem_valid, mem_rid
    );

    modport slave (
        input  mem_req, mem_wr, mem_addr, mem_data, mem_id,
        output mem_ack, mem_valid, mem_rid
    );

endinterface

// File: rtl/arb_rr_pick.sv
// Rotating priority encoder: finds the first asserted request at or after
// index ptr+1 (modulo N); index ptr itself has the lowest priority.
module rr_pick #(
    parameter int N  = 4,
    parameter int IN = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IN-1:0] ptr,
    output logic          hit,
    output logic [IN-1:0] idx
);

    logic [IN-1:0] cand;

    // Scan from farthest to nearest so the nearest hit is the one that sticks.
    always_comb begin
        hit  = 1'b0;
        idx  = '0;
        cand = '0;
        for (int k = N; k >= 1; k--) begin
            cand = IN'((int'(ptr) + k) % N);
            if (req[cand]) begin
                hit = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/arb_rr.sv
// Round-robin arbiter granting N requesters access to one memory port.
// Reads are single commands, writes are BURST-beat bursts.
// Optional build macro ARB_RR_PRI0_EN: requester 0 wins every arbitration it
// takes part in and its grants do not move the round-robin pointer.
//
// state | meaning
// IDLE  | no grant; arbitrate among requests
// READ  | single read command outstanding until mem_ack
// WRITE | write burst in progress, counting mem_ack beats
module arb_rr
    import arb_pkg::*;
#(
    parameter int AN    = ARB_AN,
    parameter int DN    = ARB_DN,
    parameter int N     = 4,
    parameter int BURST = ARB_BURST,
    parameter int IN    = $clog2(N)
) (
    input  logic          clkSYS,
    input  logic          n_reset,
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  wr,
    input  logic [N*AN-1:0] addr,
    input  logic [N*DN-1:0] data,
    output logic [N-1:0]  ack,
    output logic [N-1:0]  valid,
    arb_rr_if.master      mem
);

    localparam int CW = $clog2(BURST + 1);

    arb_state_t    state;
    arb_state_t    state_nxt;
    logic [IN-1:0] gnt;
    logic [IN-1:0] ptr;
    logic [CW-1:0] cnt;

    logic          pick_hit;
    logic [IN-1:0] pick_idx;
    logic          win_hit;
    logic [IN-1:0] win_idx;
    logic          burst_last;

    rr_pick #(
        .N  (N),
        .IN (IN)
    ) u_pick (
        .req (req),
        .ptr (ptr),
        .hit (pick_hit),
        .idx (pick_idx)
    );

`ifdef ARB_RR_PRI0_EN
    // Requester 0 overrides the rotating choice whenever it is asking.
    always_comb begin
        win_hit = pick_hit;
        win_idx = pick_idx;
        if (req[0]) begin
            win_hit = 1'b1;
            win_idx = '0;
        end
    end
`else
    // Plain round robin: the rotating encoder decides alone.
    always_comb begin
        win_hit = pick_hit;
        win_idx = pick_idx;
    end
`endif

    assign burst_last = mem.mem_ack && (cnt == CW'(BURST - 1));

    // State register.
    always_ff @(posedge clkSYS or negedge n_reset) begin
        if (!n_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; a grant always leaves at least one IDLE cycle after it.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (win_hit) begin
                    state_nxt = wr[win_idx] ? WRITE : READ;
                end
            end
            READ: begin
                if (mem.mem_ack) begin
                    state_nxt = IDLE;
                end
            end
            WRITE: begin
                if (burst_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Grant index, round-robin pointer and write beat counter.
    always_ff @(posedge clkSYS or negedge n_reset) begin
        if (!n_reset) begin
            gnt <= '0;
            ptr <= IN'(N - 1);
            cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_hit) begin
                        gnt <= win_idx;
                        cnt <= '0;
                    end
                end
                WRITE: begin
                    if (mem.mem_ack) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
            if (state != IDLE && state_nxt == IDLE) begin
`ifdef ARB_RR_PRI0_EN
                if (gnt != '0) begin
                    ptr <= gnt;
                end
`else
                ptr <= gnt;
`endif
            end
        end
    end

    // Command outputs; address/data follow the granted requester combinationally.
    always_comb begin
        mem.mem_req  = (state != IDLE);
        mem.mem_wr   = (state == WRITE);
        mem.mem_id   = gnt;
        mem.mem_addr = '0;
        mem.mem_data = '0;
        ack          = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt == IN'(i)) begin
                mem.mem_addr = addr[i*AN +: AN];
                mem.mem_data = data[i*DN +: DN];
                ack[i]       = mem.mem_ack && (state != IDLE);
            end
        end
    end

    // Read return decode, independent of arbitration state; ids >= N match nothing.
    always_comb begin
        valid = '0;
        for (int i = 0; i < N; i++) begin
            valid[i] = mem.mem_valid && (mem.mem_rid == IN'(i));
        end
    end

endmodule

// File: tb/tb_arb_rr.sv
// Directed testbench for arb_rr with default parameters (N=4, BURST=8).
module tb_arb_rr;

    localparam int AN    = 24;
    localparam int DN    = 16;
    localparam int N     = 4;
    localparam int BURST = 8;
    localparam int IN    = 2;

    logic            clkSYS = 1'b0;
    logic            n_reset;
    logic [N-1:0]    req;
    logic [N-1:0]    wr;
    logic [N*AN-1:0] addr;
    logic [N*DN-1:0] data;
    logic [N-1:0]    ack;
    logic [N-1:0]    valid;

    int checks   = 0;
    int failures = 0;

    arb_rr_if #(.AN(AN), .DN(DN), .IN(IN)) mem_bus ();

    arb_rr #(
        .AN    (AN),
        .DN    (DN),
        .N     (N),
        .BURST (BURST),
        .IN    (IN)
    ) dut (
        .clkSYS  (clkSYS),
        .n_reset (n_reset),
        .req     (req),
        .wr      (wr),
        .addr    (addr),
        .data    (data),
        .ack     (ack),
        .valid   (valid),
        .mem     (mem_bus)
    );

    always #5 clkSYS = ~clkSYS;

    function automatic logic [AN-1:0] addr_of(input int i);
        return AN'(32'h00A00000 + i * 32'h111);
    endfunction

    function automatic logic [DN-1:0] data_of(input int i);
        return DN'(32'hD000 + i);
    endfunction

    task automatic test_reset();
        n_reset = 1'b0;
        req = '0;
        wr = '0;
        mem_bus.mem_ack = 1'b0;
        mem_bus.mem_valid = 1'b0;
        mem_bus.mem_rid = '0;
        for (int i = 0; i < N; i++) begin
            addr[i*AN +: AN] = addr_of(i);
            data[i*DN +: DN] = data_of(i);
        end
        repeat (2) @(negedge clkSYS);
        #1;
        checks++;
        if (mem_bus.mem_req !== 1'b0) begin
            failures++; $display("FAIL reset_mem_req got=%b exp=0", mem_bus.mem_req);
        end
        checks++;
        if (mem_bus.mem_wr !== 1'b0) begin
            failures++; $display("FAIL reset_mem_wr got=%b exp=0", mem_bus.mem_wr);
        end
        checks++;
        if (ack !== 4'b0000) begin
            failures++; $display("FAIL reset_ack got=%b exp=0000", ack);
        end
        checks++;
        if (mem_bus.mem_id !== 2'd0) begin
            failures++; $display("FAIL reset_mem_id got=%0d exp=0", mem_bus.mem_id);
        end
        n_reset = 1'b1;
        mem_bus.mem_ack = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clkSYS);
            #1;
            checks++;
            if (mem_bus.mem_req !== 1'b0 || ack !== 4'b0000) begin
                failures++;
                $display("FAIL idle_no_req cycle=%0d mem_req=%b ack=%b exp mem_req=0 ack=0000",
                         c, mem_bus.mem_req, ack);
            end
        end
    endtask

    task automatic test_rr_reads();
        int exp_g[5];
        int seen;
        int last;
        exp_g = '{0, 1, 2, 3, 0};
        seen = 0;
        last = -1;
        req = 4'b1111;
        wr = 4'b0000;
        mem_bus.mem_ack = 1'b1;
        for (int c = 0; c < 40 && seen < 5; c++) begin
            @(negedge clkSYS);
            #1;
            if (ack !== 4'b0000) begin
                checks++;
                if (ack !== (N'(1) << exp_g[seen])) begin
                    failures++;
                    $display("FAIL rr_ack[%0d] got=%b exp=%b", seen, ack, N'(1) << exp_g[seen]);
                end
                checks++;
                if (mem_bus.mem_id !== IN'(exp_g[seen]) || mem_bus.mem_wr !== 1'b0) begin
                    failures++;
                    $display("FAIL rr_id[%0d] got id=%0d wr=%b exp id=%0d wr=0",
                             seen, mem_bus.mem_id, mem_bus.mem_wr, exp_g[seen]);
                end
                checks++;
                if (mem_bus.mem_addr !== addr_of(exp_g[seen])) begin
                    failures++;
                    $display("FAIL rr_addr[%0d] got=%h exp=%h", seen, mem_bus.mem_addr,
                             addr_of(exp_g[seen]));
                end
                if (seen > 0) begin
                    checks++;
                    if (c - last != 2) begin
                        failures++;
                        $display("FAIL rr_gap[%0d] got=%0d exp=2", seen, c - last);
                    end
                end
                last = c;
                seen++;
                if (seen == 5) req = 4'b0000;
            end
        end
        checks++;
        if (seen != 5) begin
            failures++; $display("FAIL rr_count got=%0d exp=5", seen);
        end
    endtask

    task automatic test_write_burst();
        int  beats;
        int  post;
        logic phase;
        beats = 0;
        post = 0;
        phase = 1'b1;
        req = 4'b0100;
        wr = 4'b0100;
        for (int c = 0; c < 60 && post < 4; c++) begin
            @(negedge clkSYS);
            mem_bus.mem_ack = phase;
            phase = ~phase;
            data[2*DN +: DN] = DN'(32'hB000 + c);
            #1;
            if (beats == BURST) begin
                post++;
                checks++;
                if (mem_bus.mem_req !== 1'b0 || ack !== 4'b0000) begin
                    failures++;
                    $display("FAIL wr_idle_after got mem_req=%b ack=%b exp mem_req=0 ack=0000",
                             mem_bus.mem_req, ack);
                end
            end else if (mem_bus.mem_req === 1'b1) begin
                checks++;
                if (mem_bus.mem_wr !== 1'b1 || mem_bus.mem_id !== 2'd2) begin
                    failures++;
                    $display("FAIL wr_cmd got wr=%b id=%0d exp wr=1 id=2",
                             mem_bus.mem_wr, mem_bus.mem_id);
                end
                checks++;
                if (mem_bus.mem_data !== DN'(32'hB000 + c)) begin
                    failures++;
                    $display("FAIL wr_data got=%h exp=%h", mem_bus.mem_data, DN'(32'hB000 + c));
                end
                if (ack !== 4'b0000) begin
                    checks++;
                    if (ack !== 4'b0100) begin
                        failures++; $display("FAIL wr_ack got=%b exp=0100", ack);
                    end
                    beats++;
                    if (beats == BURST) req = 4'b0000;
                end
            end
        end
        checks++;
        if (beats != BURST || post != 4) begin
            failures++; $display("FAIL wr_beats got=%0d exp=%0d", beats, BURST);
        end
        data[2*DN +: DN] = data_of(2);
    endtask

    task automatic test_midburst_request();
        int wb;
        int first;
        int last;
        int rd_seen;
        wb = 0;
        first = -1;
        last = -1;
        rd_seen = 0;
        req = 4'b0100;
        wr = 4'b0100;
        mem_bus.mem_ack = 1'b1;
        for (int c = 0; c < 40 && rd_seen == 0; c++) begin
            @(negedge clkSYS);
            #1;
            if (ack !== 4'b0000) begin
                if (wb < BURST) begin
                    checks++;
                    if (ack !== 4'b0100 || mem_bus.mem_wr !== 1'b1) begin
                        failures++;
                        $display("FAIL mid_beat[%0d] got ack=%b wr=%b exp ack=0100 wr=1",
                                 wb, ack, mem_bus.mem_wr);
                    end
                    if (wb == 0) first = c;
                    last = c;
                    wb++;
                    if (wb == 3) begin
                        req = 4'b0010;
                        wr = 4'b0000;
                    end
                end else begin
                    rd_seen = 1;
                    checks++;
                    if (ack !== 4'b0010 || mem_bus.mem_wr !== 1'b0) begin
                        failures++;
                        $display("FAIL mid_next_grant got ack=%b wr=%b exp ack=0010 wr=0",
                                 ack, mem_bus.mem_wr);
                    end
                    checks++;
                    if (c - last != 2) begin
                        failures++; $display("FAIL mid_next_gap got=%0d exp=2", c - last);
                    end
                    req = 4'b0000;
                end
            end
        end
        checks++;
        if (wb != BURST || last - first != BURST - 1) begin
            failures++;
            $display("FAIL mid_burst_len got beats=%0d span=%0d exp beats=%0d span=%0d",
                     wb, last - first, BURST, BURST - 1);
        end
        checks++;
        if (rd_seen != 1) begin
            failures++; $display("FAIL mid_read_seen got=%0d exp=1", rd_seen);
        end
    endtask

    task automatic test_reset_midburst();
        int beats;
        int first;
        int last;
        beats = 0;
        req = 4'b0100;
        wr = 4'b0100;
        mem_bus.mem_ack = 1'b1;
        for (int c = 0; c < 30 && beats < 5; c++) begin
            @(negedge clkSYS);
            #1;
            if (ack !== 4'b0000) beats++;
        end
        checks++;
        if (beats != 5) begin
            failures++; $display("FAIL rst_reach_beat5 got=%0d exp=5", beats);
        end
        n_reset = 1'b0;
        #1;
        checks++;
        if (mem_bus.mem_req !== 1'b0 || mem_bus.mem_wr !== 1'b0 || ack !== 4'b0000
            || mem_bus.mem_id !== 2'd0) begin
            failures++;
            $display("FAIL rst_mid_outputs got req=%b wr=%b ack=%b id=%0d exp 0 0 0000 0",
                     mem_bus.mem_req, mem_bus.mem_wr, ack, mem_bus.mem_id);
        end
        @(negedge clkSYS);
        n_reset = 1'b1;
        beats = 0;
        first = -1;
        last = -1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clkSYS);
            #1;
            if (ack !== 4'b0000) begin
                checks++;
                if (ack !== 4'b0100) begin
                    failures++; $display("FAIL rst_fresh_ack got=%b exp=0100", ack);
                end
                if (beats == 0) first = c;
                last = c;
                beats++;
                if (beats == BURST) req = 4'b0000;
            end
        end
        checks++;
        if (beats != BURST || last - first != BURST - 1) begin
            failures++;
            $display("FAIL rst_fresh_burst got beats=%0d span=%0d exp beats=%0d span=%0d",
                     beats, last - first, BURST, BURST - 1);
        end
        checks++;
        if (mem_bus.mem_req !== 1'b0) begin
            failures++; $display("FAIL rst_fresh_idle got=%b exp=0", mem_bus.mem_req);
        end
    endtask

    task automatic test_valid();
        logic          v_en[5];
        logic [IN-1:0] v_id[5];
        logic [N-1:0]  v_exp[5];
        v_en  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        v_id  = '{2'd3, 2'd3, 2'd0, 2'd1, 2'd0};
        v_exp = '{4'b1000, 4'b0000, 4'b0001, 4'b0010, 4'b0000};
        for (int i = 0; i < 5; i++) begin
            @(negedge clkSYS);
            mem_bus.mem_valid = v_en[i];
            mem_bus.mem_rid = v_id[i];
            #1;
            checks++;
            if (valid !== v_exp[i]) begin
                failures++;
                $display("FAIL valid[%0d] got=%b exp=%b", i, valid, v_exp[i]);
            end
        end
        mem_bus.mem_valid = 1'b0;
    endtask

    task automatic test_pri0();
        int exp_g[6];
        int seen;
`ifdef ARB_RR_PRI0_EN
        exp_g = '{0, 0, 0, 0, 0, 0};
`else
        exp_g = '{0, 1, 3, 0, 1, 3};
`endif
        seen = 0;
        @(negedge clkSYS);
        n_reset = 1'b0;
        req = 4'b0000;
        @(negedge clkSYS);
        n_reset = 1'b1;
        req = 4'b1011;
        wr = 4'b0000;
        mem_bus.mem_ack = 1'b1;
        for (int c = 0; c < 40 && seen < 6; c++) begin
            @(negedge clkSYS);
            #1;
            if (ack !== 4'b0000) begin
                checks++;
                if (ack !== (N'(1) << exp_g[seen])) begin
                    failures++;
                    $display("FAIL pri_order[%0d] got=%b exp=%b", seen, ack, N'(1) << exp_g[seen]);
                end
                seen++;
                if (seen == 6) req = 4'b0000;
            end
        end
        checks++;
        if (seen != 6) begin
            failures++; $display("FAIL pri_count got=%0d exp=6", seen);
        end
    endtask

    initial begin
        test_reset();
        test_rr_reads();
        test_write_burst();
        test_midburst_request();
        test_reset_midburst();
        test_valid();
        test_pri0();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish by time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/arb_rr.md
ARB_RR -- requirements
Module: arb_rr

Interface
REQ-001 SHALL have parameter AN, default 24, memory word address width.
REQ-002 SHALL have parameter DN, default 16, memory data width.
REQ-003 SHALL have parameter N, default 4, number of requesters; legal range 2..8.
REQ-004 SHALL have parameter BURST, default 8, words per write burst.
REQ-005 SHALL have parameter IN, default 2, id width, equal to clog2(N).
REQ-006 clkSYS  input  1  system clock; one clock; all logic on its rising edge.
REQ-007 n_reset  input  1  reset, asynchronous assert, active-low.
REQ-008 req  input  N  per-requester request level.
REQ-009 wr  input  N  per-requester write flag; 1 means write burst, 0 means single read command.
REQ-010 addr  input  N*AN  per-requester addresses, packed with requester i at bits [i*AN +: AN].
REQ-011 data  input  N*DN  per-requester write data, packed with requester i at bits [i*DN +: DN].
REQ-012 ack  output  N  one-hot acceptance strobe per beat.
REQ-013 mem_req, mem_wr  output  1 each  downstream command.
REQ-014 mem_addr  output  AN  downstream address.
REQ-015 mem_data  output  DN  downstream write data.
REQ-016 mem_id  output  IN  index of the granted requester.
REQ-017 mem_ack  input  1  downstream beat accepted.
REQ-018 mem_valid  input  1  read data return strobe.
REQ-019 mem_rid  input  IN  id of the read return.
REQ-020 valid  output  N  one-hot read return, decoded from mem_rid and qualified by mem_valid.

Function
REQ-021 FSM SHALL have states IDLE, READ and WRITE.
REQ-022 In IDLE, grant SHALL go to the first asserted req at or after index ptr+1 modulo N.
REQ-023 The IDLE-to-grant transition SHALL register the winner's index, which drives mem_id, and SHALL select READ or WRITE from wr of that index.
REQ-024 In READ or WRITE, mem_req=1 and mem_wr=state==WRITE; mem_addr and mem_data SHALL be combinationally muxed from the granted requester.
REQ-025 ack[g] SHALL equal mem_ack && state!=IDLE, with zero added latency.
REQ-026 READ SHALL return to IDLE on the first mem_ack.
REQ-027 WRITE SHALL count mem_ack beats and return to IDLE on beat BURST.
REQ-028 The beat counter SHALL be clog2(BURST+1) bits and SHALL clear on entry to WRITE.
REQ-029 On return to IDLE, ptr SHALL load the granted index, so a requester is not re-granted while another is waiting.
REQ-030 There SHALL be a minimum of one IDLE cycle between grants, so back-to-back grants are 1 cycle apart after the final ack.
REQ-031 Deassertion of req of the granted requester mid-burst SHALL be ignored; the burst completes.
REQ-032 If mem_ack is held high, a write burst SHALL complete in exactly BURST cycles.
REQ-033 With no req asserted, the FSM SHALL stay in IDLE with mem_req=0.
REQ-034 valid SHALL be purely combinational from mem_valid and mem_rid, independent of state.
REQ-035 mem_rid >= N SHALL produce valid=0.

Reset
REQ-036 Asserting n_reset low at any time, including mid-burst, SHALL immediately force state=IDLE, ptr=N-1, counter=0, mem_req=0, mem_wr=0, ack=0 and mem_id=0.
REQ-037 After n_reset is released, the first arbitration SHALL favour index 0.

Configuration
REQ-038 Macro ARB_RR_PRI0_EN SHALL, when defined, make requester 0 win any IDLE arbitration in which it is requesting, regardless of ptr, and SHALL leave ptr unchanged when 0 is granted.
REQ-039 When ARB_RR_PRI0_EN is undefined, requester 0 SHALL participate in the plain round robin.

Structure
REQ-040 Package arb_pkg SHALL hold the state enum arb_state_t {IDLE, READ, WRITE} and the default AN, DN and BURST constants.
REQ-041 Sub-module rr_pick SHALL be a parameterised, combinational rotating priority encoder with inputs req and ptr and outputs hit and idx.

Verification
REQ-042 Reset, then req=4'b1111, wr=0, mem_ack=1 -> grant order 0,1,2,3,0 with one ack per grant, each ack 2 cycles apart.
REQ-043 req[2]=1, wr[2]=1, mem_ack toggling 1,0 -> exactly 8 acks to 2; mem_wr=1 throughout; IDLE after the 8th ack; mem_data tracks data[2].
REQ-044 Mid-burst (beat 3), req[1] asserted -> no grant to 1 until beat 8 completes, then grant to 1.
REQ-045 n_reset pulsed low at write beat 5 -> mem_req=0 in the same cycle; next grant is a fresh burst of 8 beats.
REQ-046 mem_valid=1, mem_rid=3 -> valid=4'b1000; mem_rid=3 with mem_valid=0 -> valid=0.
REQ-047 With ARB_RR_PRI0_EN defined, req=4'b1011 held -> requester 0 granted every arbitration; without the macro -> order 0,1,3.
